// File: rtl/string_reader.sv
// UART 8N1 receiver that assembles incoming characters into a line buffer and
// presents each completed line as a right-aligned packed vector with a valid/ack handshake.
module string_reader #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int MAX_CHARS = 80,
    parameter int LEN_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    output logic [MAX_CHARS*8-1:0] line,
    output logic [LEN_W-1:0]       line_len,
    output logic                   line_valid,
    input  logic                   line_ack,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   line_lost
);

    localparam int BIT_TICKS  = CLK_FREQ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int TICK_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int LINE_W     = MAX_CHARS * 8;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
    localparam logic [LEN_W-1:0]  N_MAX     = LEN_W'(MAX_CHARS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic                rx_meta, rxs, rxs_prev;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift;
    logic [LINE_W-1:0]   work;
    logic [LEN_W-1:0]    n;
    logic                ovf_flag;

    logic tick_clr, bit_clr, sample_bit, byte_ok, stop_bad;
    logic is_term, is_bs;

    // Synchroniser and edge history idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true flop chain; blocking would collapse it.
            rx_meta  <= uart_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        tick_clr   = 1'b0;
        bit_clr    = 1'b0;
        sample_bit = 1'b0;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        unique case (state)
            IDLE: begin
                tick_clr = 1'b1;
                if (rxs_prev && !rxs) begin
                    bit_clr    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick_cnt == HALF_LAST) begin
                    tick_clr   = 1'b1;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_clr   = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_clr   = 1'b1;
                    state_next = IDLE;
                    byte_ok    = rxs;
                    stop_bad   = !rxs;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            tick_cnt <= tick_clr ? '0 : tick_cnt + 1'b1;
            if (bit_clr)         bit_cnt <= '0;
            else if (sample_bit) bit_cnt <= bit_cnt + 1'b1;
            if (sample_bit) shift <= {rxs, shift[7:1]};
        end
    end

    assign is_term = (shift == 8'h0A) || (shift == 8'h0D);
    assign is_bs   = (shift == 8'h08);

    // A terminator arriving while a line is still pending (even one being acked
    // this cycle) is dropped so the consumer never sees a half-updated line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide buffers are explicitly reset because an empty buffer must read as zero.
            work       <= '0;
            n          <= '0;
            ovf_flag   <= 1'b0;
            line       <= '0;
            line_len   <= '0;
            line_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            line_lost  <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            line_lost <= 1'b0;
            if (line_valid && line_ack) line_valid <= 1'b0;
            if (byte_ok) begin
                if (is_term) begin
                    if (n != '0) begin
                        if (!line_valid) begin
                            line       <= work;
                            line_len   <= n;
                            overflow   <= ovf_flag;
                            line_valid <= 1'b1;
                        end else begin
                            line_lost <= 1'b1;
                        end
                        work     <= '0;
                        n        <= '0;
                        ovf_flag <= 1'b0;
                    end
                end else if (is_bs) begin
                    if (n != '0) begin
                        work <= work >> 8;
                        n    <= n - 1'b1;
                    end
                end else if (n != N_MAX) begin
                    work <= {work[LINE_W-9:0], shift};
                    n    <= n + 1'b1;
                end else begin
                    ovf_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_string_reader.sv
// Self-checking bench for string_reader: serial stimulus with a scoreboard of
// expected lines, plus pulse counters for frame_err, line_lost and line_valid rises.
`timescale 1ns/1ps
module tb_string_reader;

    localparam int CLK_FREQ  = 1600000;
    localparam int BAUD      = 100000;
    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int MAX_CHARS = 80;
    localparam int LEN_W     = 7;
    localparam int LINE_W    = MAX_CHARS * 8;
    localparam int CLK_NS    = 10;
    localparam int BT        = BIT_TICKS * CLK_NS;

    typedef struct {
        logic [LINE_W-1:0] line;
        int                len;
        logic              ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rx = 1'b1;
    logic              line_ack = 1'b0;
    logic [LINE_W-1:0] line;
    logic [LEN_W-1:0]  line_len;
    logic              line_valid, overflow, frame_err, line_lost;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0, ll_cnt = 0, rise_cnt = 0;
    logic lv_q = 1'b0;

    string_reader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_CHARS(MAX_CHARS), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .line(line), .line_len(line_len), .line_valid(line_valid),
        .line_ack(line_ack), .overflow(overflow),
        .frame_err(frame_err), .line_lost(line_lost)
    );

    always #(CLK_NS/2) clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (line_lost === 1'b1) ll_cnt++;
        if (line_valid === 1'b1 && lv_q !== 1'b1) rise_cnt++;
        lv_q = line_valid;
    end

    task automatic push_exp(input string s, input logic ovf);
        exp_t e;
        e.line = '0;
        for (int i = 0; i < s.len(); i++) e.line = {e.line[LINE_W-9:0], s[i]};
        e.len = s.len();
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        #(BT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(BT);
        end
        uart_rx = stop_ok;
        #(BT);
        uart_rx = 1'b1;
        if (!stop_ok) #(2*BT);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic idle_bits(input int nbits);
        #(nbits*BT);
        @(negedge clk);
    endtask

    task automatic wait_line(input string name);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (line_valid !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (line_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got=%b want=1 (timeout)", name, line_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got unexpected line len=%0d want=none", name, line_len);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (line !== e.line) begin
            errors++;
            $display("FAIL %s line: got=%h want=%h", name, line, e.line);
        end
        checks++;
        if (line_len !== LEN_W'(e.len)) begin
            errors++;
            $display("FAIL %s len: got=%0d want=%0d", name, line_len, e.len);
        end
        checks++;
        if (overflow !== e.ovf) begin
            errors++;
            $display("FAIL %s overflow: got=%b want=%b", name, overflow, e.ovf);
        end
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        checks++;
        if (line_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: valid got=%b want=0", name, line_valid);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (line !== '0 || line_len !== '0 || line_valid !== 1'b0 ||
            overflow !== 1'b0 || frame_err !== 1'b0 || line_lost !== 1'b0) begin
            errors++;
            $display("FAIL %s: got len=%0d valid=%b ovf=%b fe=%b lost=%b line_nonzero=%b want all 0",
                     name, line_len, line_valid, overflow, frame_err, line_lost, |line);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_basic();
        push_exp("Hi", 1'b0);
        send_str("Hi\r");
        wait_line("basic");
        do_ack("basic");
    endtask

    task automatic test_crlf();
        int r0 = rise_cnt;
        int l0 = ll_cnt;
        push_exp("AB", 1'b0);
        send_str("AB\r\n");
        wait_line("crlf");
        do_ack("crlf");
        idle_bits(20);
        checks++;
        if (rise_cnt - r0 != 1 || ll_cnt != l0 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL crlf single: got rises=%0d lost=%0d valid=%b want rises=1 lost=0 valid=0",
                     rise_cnt - r0, ll_cnt - l0, line_valid);
        end
    endtask

    task automatic test_backspace();
        push_exp("ABD", 1'b0);
        send_str("ABC");
        send_byte(8'h08, 1'b1);
        send_str("D\n");
        wait_line("backspace");
        do_ack("backspace");
    endtask

    task automatic test_overflow();
        string s = "";
        for (int i = 0; i < MAX_CHARS; i++) s = {s, "x"};
        push_exp(s, 1'b1);
        for (int i = 0; i < MAX_CHARS + 5; i++) send_byte(8'h78, 1'b1);
        send_byte(8'h0A, 1'b1);
        wait_line("overflow");
        do_ack("overflow");
    endtask

    task automatic test_frame_err();
        int f0 = fe_cnt;
        send_str("Y");
        send_byte(8'h55, 1'b0);
        checks++;
        if (fe_cnt - f0 != 1 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err pulse: got cycles=%0d valid=%b want cycles=1 valid=0",
                     fe_cnt - f0, line_valid);
        end
        push_exp("YZ", 1'b0);
        send_str("Z\n");
        wait_line("frame_err_after");
        do_ack("frame_err_after");
    endtask

    task automatic test_back_to_back();
        int l0;
        push_exp("A", 1'b0);
        send_str("A\n");
        wait_line("b2b_first");
        l0 = ll_cnt;
        send_str("B\n");
        idle_bits(1);
        checks++;
        if (ll_cnt - l0 != 1) begin
            errors++;
            $display("FAIL b2b lost: got pulses=%0d want=1", ll_cnt - l0);
        end
        checks++;
        if (line !== LINE_W'(8'h41) || line_len !== LEN_W'(1) || line_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b held: got line[15:0]=%h len=%0d valid=%b want 0041 1 1",
                     line[15:0], line_len, line_valid);
        end
        do_ack("b2b");
    endtask

    task automatic test_reset_mid_data();
        push_exp("R", 1'b0);
        send_str("R\n");
        wait_line("mid_pending");
        uart_rx = 1'b0;
        #(BT);
        uart_rx = 1'b1;
        #(BT);
        uart_rx = 1'b0;
        #(BT/2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(3);
        push_exp("Q", 1'b0);
        send_str("Q\n");
        wait_line("after_reset");
        do_ack("after_reset");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crlf();
        test_backspace();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
